vending_ledger: RTL
===================

# vending_ledger

Balance and change ledger for the auto vending machine, running on the 25 kHz system clock. It sits beside the vending FSM and does three things:
- consumes the FSM's one-cycle coin-done, pay-start and charge-start pulses;
- returns the combinational `nonenough_flag` that the FSM samples at the end of its pay delay;
- tracks the customer balance, deducts the selected item's price and vends, and pays change back as a timed sequence of coins, largest denomination first.

## Interface
Parameters:
- `BAL_W`, 8, balance width in coin units.
- `MAX_BAL`, 255, balance saturation ceiling (≤ 2^BAL_W − 1).
- `PRICE0`..`PRICE3`, 3 / 5 / 12 / 20, prices of items 0..3 in units.
- `DISP_GAP`, 2, idle cycles between consecutive change coins (≥ 0).

Ports:
- `clk` in 1: system clock. One clock domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `sel_load` in 1: pulse; latch `item_sel` as the current item.
- `item_sel` in 2: item index.
- `coin_fn_flag` in 1: pulse; accept one coin of value `coin_val`.
- `coin_val` in 2: coin code. 00 = 1, 01 = 5, 10 = 10, 11 = 20 units.
- `pay_st_flag` in 1: pulse; attempt purchase.
- `charge_st_flag` in 1: pulse; start change payout.
- `nonenough_flag` out 1: combinational, `!price_valid || balance < price`.
- `balance` out BAL_W: registered balance.
- `price` out BAL_W: latched price.
- `vend_pulse` out 1: one cycle per successful purchase.
- `coin_out_valid` out 1: one-cycle pulse per change coin.
- `coin_out_val` out 2: code of the coin being emitted. Valid with `coin_out_valid`; 00 otherwise.
- `chg_busy` out 1: high while change is being paid out.
- `chg_done` out 1: one-cycle pulse at the end of payout.

## Operation
- Reset values:
  - `balance`, `price`, `price_valid` = 0.
  - All pulse outputs = 0; `coin_out_val` = 00.
  - `chg_busy` = 0; state = IDLE.
  - Consequence: `nonenough_flag` = 1 out of reset.
- Selection:
  - `sel_load` loads `price` from `PRICEn[item_sel]` and sets `price_valid`.
  - Honoured in any state.
- Coin:
  - In IDLE, `coin_fn_flag` adds the coin value to `balance`.
  - The sum is computed at BAL_W+1 bits and saturates at `MAX_BAL`.
- Pay:
  - In IDLE, `pay_st_flag` is evaluated against the registered balance.
  - If `nonenough_flag` = 0: `balance` ← `balance` − `price` and `vend_pulse` = 1 on the next cycle.
  - Otherwise `balance` is unchanged and there is no vend.
- Coin and pay in the same cycle:
  - Sufficiency is judged on the old balance.
  - New balance = sat(old + coin − price if sufficient, else old + coin).
- Change state machine: IDLE → EMIT → GAP → EMIT … → DONE → IDLE.
  - IDLE: `charge_st_flag` → EMIT. `chg_busy` = 1 from the next cycle.
  - EMIT: choose the largest coin ≤ `balance` (20, 10, 5, 1). Pulse `coin_out_valid` with its code and subtract its value. If the remainder is 0 → DONE; else → GAP, or straight back to EMIT when `DISP_GAP` = 0.
  - GAP: wait `DISP_GAP` cycles, then → EMIT.
  - DONE: pulse `chg_done`, clear `chg_busy`, → IDLE.
  - `charge_st_flag` with `balance` = 0: EMIT goes straight to DONE with no coin.
- While `chg_busy`: `coin_fn_flag`, `pay_st_flag` and `charge_st_flag` are ignored and dropped.
- Reset mid-payout aborts immediately. `balance` is cleared; coins not yet emitted are lost.

## Timing
- `nonenough_flag` is combinational from registers. It is valid in the same cycle the FSM raises `pay_st_flag`.
- `balance`, `vend_pulse` and `price` update one cycle after the triggering pulse.
- Change coin k (k = 0, 1, …) pulses at cycle t + 1 + k·(DISP_GAP + 1), where t is the `charge_st_flag` cycle.
- `chg_done` asserts the cycle after the last coin. `chg_busy` covers t+1 through the `chg_done` cycle inclusive.

## Configuration
- `LEDGER_SALES_CNT_EN` defined:
  - Adds output `sales_cnt` [15:0], reset 0.
  - Increments on each `vend_pulse` and wraps at 0xFFFF → 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Reset, then `sel_load` item 2 → `price` = 12, `nonenough_flag` = 1. Coins 5 and 10 → `balance` = 15, `nonenough_flag` = 0.
- `pay_st_flag` at balance 15, price 12 → `vend_pulse` once, `balance` = 3, `nonenough_flag` = 1. A second pay → no vend, `balance` stays 3.
- Balance 250, coin 20 → `balance` = 255 (saturated). Coin 10 and pay (price 5) in the same cycle at balance 3 → `balance` = 13, no vend.
- Balance 38, `DISP_GAP` = 2, charge at t:
  - coins 20, 10, 5, 1, 1, 1 at t+1, t+4, t+7, t+10, t+13, t+16;
  - `chg_done` at t+17, `balance` = 0;
  - a coin injected at t+5 is ignored.
- Charge at balance 0 → no `coin_out_valid`, `chg_done` at t+2.
- `rst_n` low at t+5 of a payout → all outputs return to reset values asynchronously; no further coins. With `LEDGER_SALES_CNT_EN`, `sales_cnt` counts 2 after two vends and resets to 0.

Source files
------------

// File: rtl/vending_ledger.sv
// Balance and change ledger beside the vending FSM: coin intake, purchase, timed change payout.
// Defining LEDGER_SALES_CNT_EN adds a 16-bit wrapping sales counter output.
module vending_ledger #(
    parameter int BAL_W    = 8,
    parameter int MAX_BAL  = 255,
    parameter int PRICE0   = 3,
    parameter int PRICE1   = 5,
    parameter int PRICE2   = 12,
    parameter int PRICE3   = 20,
    parameter int DISP_GAP = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sel_load,
    input  logic [1:0]       item_sel,
    input  logic             coin_fn_flag,
    input  logic [1:0]       coin_val,
    input  logic             pay_st_flag,
    input  logic             charge_st_flag,
    output logic             nonenough_flag,
    output logic [BAL_W-1:0] balance,
    output logic [BAL_W-1:0] price,
    output logic             vend_pulse,
    output logic             coin_out_valid,
    output logic [1:0]       coin_out_val,
    output logic             chg_busy,
    output logic             chg_done
`ifdef LEDGER_SALES_CNT_EN
    ,
    output logic [15:0]      sales_cnt
`endif
);
    localparam int W1    = BAL_W + 1;
    localparam int GAP_W = (DISP_GAP > 1) ? $clog2(DISP_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((DISP_GAP > 0) ? DISP_GAP - 1 : 0);
    localparam logic [W1-1:0]    SAT      = W1'(MAX_BAL);

    typedef enum logic [1:0] {S_IDLE, S_EMIT, S_GAP, S_DONE} state_t;

    state_t           state, state_next;
    logic             price_valid;
    logic [GAP_W-1:0] gap_cnt;
    logic [BAL_W-1:0] bal_next;
    logic             vend_next;
    logic [W1-1:0]    bal_ext, sum, emit_units;

    function automatic logic [W1-1:0] coin_units(input logic [1:0] code);
        case (code)
            2'b00:   return W1'(1);
            2'b01:   return W1'(5);
            2'b10:   return W1'(10);
            default: return W1'(20);
        endcase
    endfunction

    function automatic logic [BAL_W-1:0] price_of(input logic [1:0] sel);
        case (sel)
            2'b00:   return BAL_W'(PRICE0);
            2'b01:   return BAL_W'(PRICE1);
            2'b10:   return BAL_W'(PRICE2);
            default: return BAL_W'(PRICE3);
        endcase
    endfunction

    assign bal_ext        = {1'b0, balance};
    assign nonenough_flag = !price_valid || (balance < price);
    assign chg_busy       = (state != S_IDLE);

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next     = state;
        bal_next       = balance;
        vend_next      = 1'b0;
        coin_out_valid = 1'b0;
        coin_out_val   = 2'b00;
        chg_done       = 1'b0;
        sum            = bal_ext;
        emit_units     = '0;
        case (state)
            S_IDLE: begin
                // Sufficiency uses the registered balance even when a coin lands in the same cycle.
                if (coin_fn_flag) sum = sum + coin_units(coin_val);
                if (pay_st_flag && !nonenough_flag) begin
                    sum       = sum - {1'b0, price};
                    vend_next = 1'b1;
                end
                bal_next = (sum > SAT) ? SAT[BAL_W-1:0] : sum[BAL_W-1:0];
                if (charge_st_flag) state_next = S_EMIT;
            end
            S_EMIT: begin
                if (bal_ext == '0) begin
                    state_next = S_DONE;
                end else begin
                    if (bal_ext >= coin_units(2'b11))      coin_out_val = 2'b11;
                    else if (bal_ext >= coin_units(2'b10)) coin_out_val = 2'b10;
                    else if (bal_ext >= coin_units(2'b01)) coin_out_val = 2'b01;
                    else                                   coin_out_val = 2'b00;
                    emit_units     = coin_units(coin_out_val);
                    coin_out_valid = 1'b1;
                    bal_next       = BAL_W'(bal_ext - emit_units);
                    if (bal_ext == emit_units) state_next = S_DONE;
                    else if (DISP_GAP == 0)    state_next = S_EMIT;
                    else                       state_next = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_cnt == GAP_LAST) state_next = S_EMIT;
            end
            S_DONE: begin
                chg_done   = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            balance    <= '0;
            vend_pulse <= 1'b0;
            gap_cnt    <= '0;
        end else begin
            state      <= state_next;
            balance    <= bal_next;
            vend_pulse <= vend_next;
            gap_cnt    <= (state == S_GAP) ? gap_cnt + 1'b1 : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            price       <= '0;
            price_valid <= 1'b0;
        end else if (sel_load) begin
            price       <= price_of(item_sel);
            price_valid <= 1'b1;
        end
    end

`ifdef LEDGER_SALES_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         sales_cnt <= '0;
        else if (vend_next) sales_cnt <= sales_cnt + 16'd1;
    end
`endif

endmodule
